// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types and width helpers for the set-associative TLB.
//   tlb_state_e  - controller FSM state (IDLE / FLUSH)
//   tlb_entry_t  - one TLB entry; fields are sized for the widest supported
//                  configuration and narrower values are stored zero-extended
//   tlb_idx_w    - set index width for a given set count
//   tlb_tag_w    - tag width for a given VA width, page offset and set count
package tlb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } tlb_state_e;

    localparam int TLB_TAG_MAX_W  = 64;
    localparam int TLB_PCID_MAX_W = 32;
    localparam int TLB_PPN_MAX_W  = 64;

    typedef struct packed {
        logic                      valid;
        logic [TLB_TAG_MAX_W-1:0]  tag;
        logic [TLB_PCID_MAX_W-1:0] pcid;
        logic [TLB_PPN_MAX_W-1:0]  ppn;
    } tlb_entry_t;

    function automatic int tlb_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tlb_tag_w(input int va_w, input int off_w, input int sets);
        return va_w - off_w - $clog2(sets);
    endfunction

endpackage

// File: rtl/tlb_set.sv
// tlb_set: one set of the TLB - WAYS entries, lookup match, fill placement,
// flush clearing and the round-robin victim pointer.
//   i_lk_tag/i_lk_pcid       -> o_lk_way (one-hot hit), o_lk_ppn (0 on miss)
//   i_fill_en + tag/pcid/ppn -> install (in-place update, free way, or victim)
//   i_flush_en               -> clear entries of i_flush_pcid (or all)
// Fill and flush are never enabled in the same cycle by the controller.
module tlb_set
    import tlb_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int TAG_W  = 49,
    parameter int PCID_W = 12,
    parameter int PPN_W  = 52
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TAG_W-1:0]  i_lk_tag,
    input  logic [PCID_W-1:0] i_lk_pcid,
    output logic [WAYS-1:0]   o_lk_way,
    output logic [PPN_W-1:0]  o_lk_ppn,
    input  logic              i_fill_en,
    input  logic [TAG_W-1:0]  i_fill_tag,
    input  logic [PCID_W-1:0] i_fill_pcid,
    input  logic [PPN_W-1:0]  i_fill_ppn,
    input  logic              i_flush_en,
    input  logic              i_flush_all,
    input  logic [PCID_W-1:0] i_flush_pcid
);

    localparam int VIC_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    tlb_entry_t       r_ent [WAYS];
    logic [VIC_W-1:0] r_vic;

    logic [TLB_TAG_MAX_W-1:0]  w_lk_tag, w_fill_tag;
    logic [TLB_PCID_MAX_W-1:0] w_lk_pcid, w_fill_pcid, w_flush_pcid;
    logic [TLB_PPN_MAX_W-1:0]  w_fill_ppn, w_lk_ppn_full;

    assign w_lk_tag     = TLB_TAG_MAX_W'(i_lk_tag);
    assign w_fill_tag   = TLB_TAG_MAX_W'(i_fill_tag);
    assign w_lk_pcid    = TLB_PCID_MAX_W'(i_lk_pcid);
    assign w_fill_pcid  = TLB_PCID_MAX_W'(i_fill_pcid);
    assign w_flush_pcid = TLB_PCID_MAX_W'(i_flush_pcid);
    assign w_fill_ppn   = TLB_PPN_MAX_W'(i_fill_ppn);

    // Fills never duplicate a (tag, pcid), so at most one way matches and
    // OR-ing the matching ppns selects it.
    always_comb begin
        o_lk_way      = '0;
        w_lk_ppn_full = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_ent[w].valid && r_ent[w].tag == w_lk_tag && r_ent[w].pcid == w_lk_pcid) begin
                o_lk_way[w]   = 1'b1;
                w_lk_ppn_full = w_lk_ppn_full | r_ent[w].ppn;
            end
        end
    end

    assign o_lk_ppn = w_lk_ppn_full[PPN_W-1:0];

    // Fill placement: existing (tag, pcid) first, then the lowest free way,
    // then the victim pointer. Descending scans leave the lowest index.
    logic             w_fill_match, w_has_free, w_use_vic;
    logic [VIC_W-1:0] w_match_idx, w_free_idx, w_tgt;

    always_comb begin
        w_fill_match = 1'b0;
        w_match_idx  = '0;
        w_has_free   = 1'b0;
        w_free_idx   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_ent[w].valid && r_ent[w].tag == w_fill_tag && r_ent[w].pcid == w_fill_pcid) begin
                w_fill_match = 1'b1;
                w_match_idx  = VIC_W'(w);
            end
            if (!r_ent[w].valid) begin
                w_has_free = 1'b1;
                w_free_idx = VIC_W'(w);
            end
        end
    end

    assign w_use_vic = !w_fill_match && !w_has_free;
    assign w_tgt     = w_fill_match ? w_match_idx : (w_has_free ? w_free_idx : r_vic);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                r_ent[w] <= '0;
            end
            r_vic <= '0;
        end else if (i_flush_en) begin
            // Flush only clears valid bits; the victim pointer is left alone.
            for (int w = 0; w < WAYS; w++) begin
                if (i_flush_all || r_ent[w].pcid == w_flush_pcid) begin
                    r_ent[w].valid <= 1'b0;
                end
            end
        end else if (i_fill_en) begin
            r_ent[w_tgt] <= '{valid: 1'b1, tag: w_fill_tag, pcid: w_fill_pcid, ppn: w_fill_ppn};
            if (w_use_vic) begin
                r_vic <= (r_vic == VIC_W'(WAYS - 1)) ? '0 : r_vic + VIC_W'(1);
            end
        end
    end

endmodule

// File: rtl/tlb_assoc.sv
// tlb_assoc: set-associative TLB with PCID tagging, single-cycle lookup,
// fill-on-request and a set-by-set flush engine.
//   req_*   : lookup request; response one cycle later on resp_*
//   fill_*  : install a translation
//   flush_* : invalidate by PCID or everything; busy while sweeping sets
//   dbg_state : current controller FSM state
// Handshake: req_ready and fill_ready are high whenever the controller is
// IDLE. A request/fill is accepted on a rising edge where valid && ready and
// flush_valid is low; flush_valid in IDLE wins and the others are dropped.
// A lookup accepted in the same cycle as a fill sees the pre-fill contents.
module tlb_assoc
    import tlb_pkg::*;
#(
    parameter int SETS   = 8,
    parameter int WAYS   = 4,
    parameter int VA_W   = 64,
    parameter int PA_W   = 64,
    parameter int PCID_W = 12,
    parameter int OFF_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [VA_W-1:0]   req_va,
    input  logic [PCID_W-1:0] req_pcid,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [PA_W-1:0]   resp_pa,
    output logic [WAYS-1:0]   resp_way,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [VA_W-1:0]   fill_va,
    input  logic [PCID_W-1:0] fill_pcid,
    input  logic [PA_W-1:0]   fill_pa,
    input  logic              flush_valid,
    input  logic              flush_all,
    input  logic [PCID_W-1:0] flush_pcid,
    output logic              busy,
    output tlb_state_e        dbg_state
);

    localparam int IDX_W = tlb_idx_w(SETS);
    localparam int TAG_W = tlb_tag_w(VA_W, OFF_W, SETS);
    localparam int PPN_W = PA_W - OFF_W;

    tlb_state_e        r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_flush_idx;
    logic              r_flush_all;
    logic [PCID_W-1:0] r_flush_pcid;

    logic              r_resp_valid, r_resp_hit;
    logic [PA_W-1:0]   r_resp_pa;
    logic [WAYS-1:0]   r_resp_way;

    logic              w_idle, w_req_acc, w_fill_acc, w_flush_start, w_flush_last;
    logic [IDX_W-1:0]  w_req_idx, w_fill_idx;
    logic [TAG_W-1:0]  w_req_tag, w_fill_tag;
    logic [PPN_W-1:0]  w_fill_ppn;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_flush_start = w_idle && flush_valid;
    assign w_req_acc     = w_idle && req_valid && !flush_valid;
    assign w_fill_acc    = w_idle && fill_valid && !flush_valid;
    assign w_flush_last  = (r_flush_idx == IDX_W'(SETS - 1));

    assign w_req_idx  = req_va[OFF_W +: IDX_W];
    assign w_req_tag  = req_va[VA_W-1 : OFF_W+IDX_W];
    assign w_fill_idx = fill_va[OFF_W +: IDX_W];
    assign w_fill_tag = fill_va[VA_W-1 : OFF_W+IDX_W];
    assign w_fill_ppn = fill_pa[PA_W-1 : OFF_W];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (flush_valid) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_flush_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_flush_idx  <= '0;
            r_flush_all  <= 1'b0;
            r_flush_pcid <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_flush_start) begin
                r_flush_idx  <= '0;
                r_flush_all  <= flush_all;
                r_flush_pcid <= flush_pcid;
            end else if (r_state == ST_FLUSH) begin
                r_flush_idx <= r_flush_idx + IDX_W'(1);
            end
        end
    end

    logic [WAYS-1:0]  w_set_way [SETS];
    logic [PPN_W-1:0] w_set_ppn [SETS];

    for (genvar s = 0; s < SETS; s++) begin : g_set
        tlb_set #(
            .WAYS   (WAYS),
            .TAG_W  (TAG_W),
            .PCID_W (PCID_W),
            .PPN_W  (PPN_W)
        ) u_set (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_lk_tag     (w_req_tag),
            .i_lk_pcid    (req_pcid),
            .o_lk_way     (w_set_way[s]),
            .o_lk_ppn     (w_set_ppn[s]),
            .i_fill_en    (w_fill_acc && (w_fill_idx == IDX_W'(s))),
            .i_fill_tag   (w_fill_tag),
            .i_fill_pcid  (fill_pcid),
            .i_fill_ppn   (w_fill_ppn),
            .i_flush_en   ((r_state == ST_FLUSH) && (r_flush_idx == IDX_W'(s))),
            .i_flush_all  (r_flush_all),
            .i_flush_pcid (r_flush_pcid)
        );
    end

    logic [WAYS-1:0]  w_lk_way;
    logic [PPN_W-1:0] w_lk_ppn;
    logic             w_lk_hit;

    assign w_lk_way = w_set_way[w_req_idx];
    assign w_lk_ppn = w_set_ppn[w_req_idx];
    assign w_lk_hit = |w_lk_way;

    // Response fields are forced to zero on a miss and when no response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_pa    <= '0;
            r_resp_way   <= '0;
        end else begin
            r_resp_valid <= w_req_acc;
            r_resp_hit   <= w_req_acc && w_lk_hit;
            r_resp_way   <= (w_req_acc && w_lk_hit) ? w_lk_way : '0;
            r_resp_pa    <= (w_req_acc && w_lk_hit) ? {w_lk_ppn, req_va[OFF_W-1:0]} : '0;
        end
    end

    assign req_ready  = w_idle;
    assign fill_ready = w_idle;
    assign busy       = (r_state == ST_FLUSH);
    assign dbg_state  = r_state;
    assign resp_valid = r_resp_valid;
    assign resp_hit   = r_resp_hit;
    assign resp_pa    = r_resp_pa;
    assign resp_way   = r_resp_way;

endmodule

// File: doc/tlb_assoc.md
TLB_ASSOC -- requirements
Module: tlb_assoc

Interface
REQ-001 Parameter SETS, default 8, number of sets; power of two, at least 2.
REQ-002 Parameter WAYS, default 4, ways per set; at least 1.
REQ-003 Parameter VA_W, default 64, virtual address width.
REQ-004 Parameter PA_W, default 64, physical address width.
REQ-005 Parameter PCID_W, default 12, process-context ID width.
REQ-006 Parameter OFF_W, default 12, page offset width.
REQ-007 Port clk, input, 1, sole clock; all state on rising edge.
REQ-008 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-009 Port req_valid, input, 1, lookup request.
REQ-010 Port req_ready, output, 1, lookup accepted this cycle.
REQ-011 Port req_va, input, VA_W, lookup virtual address.
REQ-012 Port req_pcid, input, PCID_W, lookup context.
REQ-013 Port resp_valid, output, 1, lookup result valid.
REQ-014 Port resp_hit, output, 1, translation found.
REQ-015 Port resp_pa, output, PA_W, translated address; 0 on miss.
REQ-016 Port resp_way, output, WAYS, one-hot way that hit; 0 on miss.
REQ-017 Port fill_valid, input, 1, install request; fill_ready, output, 1, install accepted.
REQ-018 Ports fill_va (VA_W), fill_pcid (PCID_W), fill_pa (PA_W), inputs, entry to install.
REQ-019 Port flush_valid, input, 1, invalidate request; flush_all, input, 1, ignore PCID; flush_pcid, input, PCID_W, context to flush.
REQ-020 Port busy, output, 1, flush in progress.

Function
REQ-021 Set index = va[OFF_W +: log2(SETS)]; tag = va[VA_W-1 : OFF_W+log2(SETS)]; entry stores valid, tag, pcid, ppn = pa[PA_W-1:OFF_W].
REQ-022 FSM states IDLE and FLUSH; req_ready = fill_ready = (state == IDLE).
REQ-023 Lookup latency exactly 1 cycle: accepted request at edge N gives resp_valid=1 after edge N, for one cycle only.
REQ-024 Hit = valid and tag match and pcid match in the indexed set; resp_pa = {ppn, req_va[OFF_W-1:0]}.
REQ-025 Entries never duplicate a (tag, pcid) in a set; more than one matching way is unreachable.
REQ-026 Fill matching an existing (tag, pcid) overwrites that way's ppn in place.
REQ-027 Otherwise fill writes the lowest-index invalid way; if the set is full, it writes the set's round-robin victim pointer, which then increments mod WAYS.
REQ-028 Lookup and fill in the same cycle: lookup reads pre-fill contents; the fill is visible from the next cycle.
REQ-029 flush_valid in IDLE (priority over req/fill the same cycle; those are not accepted): enter FLUSH, busy=1, latch flush_all/flush_pcid.
REQ-030 FLUSH processes one set per cycle, index 0..SETS-1; it clears valid where flush_all or pcid == latched pcid; after set SETS-1 it returns to IDLE; busy high exactly SETS cycles.
REQ-031 flush_valid during FLUSH is ignored.
REQ-032 Victim pointers are not changed by flush.

Reset
REQ-033 rst_n low asynchronously: all valid bits 0, victim pointers 0, state IDLE, busy 0, resp_valid 0, resp_hit 0, resp_pa 0, resp_way 0.
REQ-034 Reset mid-FLUSH or mid-response aborts it; the first cycle after release is IDLE with an empty TLB.

Structure
REQ-035 Package tlb_pkg holds the FSM state enum, the entry struct, and index/tag width functions.
REQ-036 One sub-module, tlb_set, holds one set's ways, match logic and victim pointer, instantiated SETS times.

Verification
REQ-037 Reset, then lookup va=0x1234 pcid=0 -> resp_valid=1 next cycle, resp_hit=0, resp_pa=0, resp_way=0.
REQ-038 Fill va=0x5000 pcid=3 pa=0xABC000, then lookup va=0x5123 pcid=3 -> hit, resp_pa=0xABC123; same va with pcid=4 -> miss.
REQ-039 Fill WAYS+1 distinct tags into set 0 (SETS=8: va=0x0, 0x8000, 0x10000, ...) -> the last fill evicts way 0; the first va misses and all others hit.
REQ-040 Fill pcid 1 and pcid 2 entries, flush_pcid=1 flush_all=0 -> busy for 8 cycles, req_ready=0; afterwards pcid 1 misses and pcid 2 hits.
REQ-041 Lookup and fill of the same va in one cycle -> that response misses; a repeat lookup next cycle hits.
REQ-042 Assert rst_n=0 in the 3rd FLUSH cycle -> busy=0 immediately; after release, all lookups miss.
